// File: rtl/janela_pkg.sv
// janela_pkg: constants and state type shared by the input-window block.
//   WIN_SIZE  - samples in one complete window
//   STEP_SIZE - fresh samples loaded between consecutive windows of a row
//   KEEP_SIZE - samples carried over from one window to the next
//   state_t   - FILL / HOLD / STEP states of the window sequencer
package janela_pkg;

  localparam int STEP_SIZE = 9;
  localparam int KEEP_SIZE = 7;
  localparam int WIN_SIZE  = STEP_SIZE + KEEP_SIZE;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    STEP = 2'd2
  } state_t;

endpackage

// File: rtl/janela_entrada.sv
// janela_entrada: builds 16-sample sliding windows from a row-ordered sample
// stream and hands each complete window to the filter bank.
//
// Ports
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   in_sample         - signed DATA_WIDTH+2 sample of the current row
//   in_valid/in_first - sample valid / sample starts a new row
//   in_ready          - block takes a sample this cycle
//   win_0 .. win_15   - window, win_0 oldest, win_15 newest
//   win_valid         - window complete and stable
//   win_ready         - downstream consumes the window
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The input side (in_valid/in_ready) and the output side
// (win_valid/win_ready) are never active in the same cycle: in_ready is 0
// exactly when win_valid is 1, so the window cannot move while it is offered.
//
// Sequencing: FILL loads a full window, HOLD offers it, STEP loads 9 new
// samples on top of the 7 newest of the previous window. A sample flagged
// in_first restarts a row from FILL with that sample already counted.
module janela_entrada
  import janela_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH+1:0] in_sample,
  input  logic                         in_valid,
  input  logic                         in_first,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH+1:0] win_0,
  output logic signed [DATA_WIDTH+1:0] win_1,
  output logic signed [DATA_WIDTH+1:0] win_2,
  output logic signed [DATA_WIDTH+1:0] win_3,
  output logic signed [DATA_WIDTH+1:0] win_4,
  output logic signed [DATA_WIDTH+1:0] win_5,
  output logic signed [DATA_WIDTH+1:0] win_6,
  output logic signed [DATA_WIDTH+1:0] win_7,
  output logic signed [DATA_WIDTH+1:0] win_8,
  output logic signed [DATA_WIDTH+1:0] win_9,
  output logic signed [DATA_WIDTH+1:0] win_10,
  output logic signed [DATA_WIDTH+1:0] win_11,
  output logic signed [DATA_WIDTH+1:0] win_12,
  output logic signed [DATA_WIDTH+1:0] win_13,
  output logic signed [DATA_WIDTH+1:0] win_14,
  output logic signed [DATA_WIDTH+1:0] win_15,
  output logic                         win_valid,
  input  logic                         win_ready
);

  localparam int SW = DATA_WIDTH + 2;

  // Count value seen on the accept that completes each phase.
  localparam logic [4:0] FILL_LAST = 5'(WIN_SIZE - 1);
  localparam logic [4:0] STEP_LAST = 5'(STEP_SIZE - 1);

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic signed [SW-1:0] win_q [WIN_SIZE];
  logic              accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    // Gated by rst so nothing is taken while reset is held.
    in_ready  = (state_q != HOLD) & ~rst;
    win_valid = (state_q == HOLD);
    case (state_q)
      FILL: begin
        if (accept) begin
          if (in_first) begin
            cnt_d = 5'd1;
          end else if (cnt_q == FILL_LAST) begin
            state_d = HOLD;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      STEP: begin
        if (accept) begin
          if (in_first) begin
            // New row: the partial window is dropped, this sample counts as 1.
            state_d = FILL;
            cnt_d   = 5'd1;
          end else if (cnt_q == STEP_LAST) begin
            state_d = HOLD;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      HOLD: begin
        if (win_ready) begin
          state_d = STEP;
          cnt_d   = 5'd0;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Shift register: oldest sample drops out of win_0, new one enters win_15.
  // After 9 shifts in STEP the old win_9..win_15 sit in win_0..win_6.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < WIN_SIZE; k++) win_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < WIN_SIZE - 1; k++) win_q[k] <= win_q[k+1];
      win_q[WIN_SIZE-1] <= in_sample;
    end
  end

  assign win_0  = win_q[0];
  assign win_1  = win_q[1];
  assign win_2  = win_q[2];
  assign win_3  = win_q[3];
  assign win_4  = win_q[4];
  assign win_5  = win_q[5];
  assign win_6  = win_q[6];
  assign win_7  = win_q[7];
  assign win_8  = win_q[8];
  assign win_9  = win_q[9];
  assign win_10 = win_q[10];
  assign win_11 = win_q[11];
  assign win_12 = win_q[12];
  assign win_13 = win_q[13];
  assign win_14 = win_q[14];
  assign win_15 = win_q[15];

endmodule

// File: tb/tb_janela_entrada.sv
// Testbench for janela_entrada: directed scenarios plus a random-valid run,
// with a scoreboard of expected windows built from the accepted sample stream.
module tb_janela_entrada;

  localparam int DW = 8;
  localparam int SW = DW + 2;
  localparam int WN = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [SW-1:0] in_sample = '0;
  logic                 in_valid  = 1'b0;
  logic                 in_first  = 1'b0;
  logic                 in_ready;
  logic                 win_valid;
  logic                 win_ready = 1'b0;
  logic signed [SW-1:0] w [WN];

  janela_entrada #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_sample(in_sample), .in_valid(in_valid), .in_first(in_first), .in_ready(in_ready),
    .win_0(w[0]),   .win_1(w[1]),   .win_2(w[2]),   .win_3(w[3]),
    .win_4(w[4]),   .win_5(w[5]),   .win_6(w[6]),   .win_7(w[7]),
    .win_8(w[8]),   .win_9(w[9]),   .win_10(w[10]), .win_11(w[11]),
    .win_12(w[12]), .win_13(w[13]), .win_14(w[14]), .win_15(w[15]),
    .win_valid(win_valid), .win_ready(win_ready)
  );

  logic [WN*SW-1:0] dut_win;
  always_comb begin
    dut_win = '0;
    for (int k = 0; k < WN; k++) dut_win[k*SW +: SW] = w[k];
  end

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- reference model / scoreboard ----------------
  // Window = last 16 accepted samples of the row; first window after 16
  // samples of a row, then one every 9 further samples.
  logic [WN*SW-1:0]     exp_q[$];
  logic signed [SW-1:0] row_q[$];
  int                   m_cnt  = 0;
  int                   m_need = 16;

  task automatic model_clear();
    exp_q.delete();
    row_q.delete();
    m_cnt  = 0;
    m_need = 16;
  endtask

  task automatic model_accept(input logic signed [SW-1:0] v, input logic first);
    logic [WN*SW-1:0] e;
    if (first) begin
      row_q.delete();
      m_cnt  = 0;
      m_need = 16;
    end
    row_q.push_back(v);
    if (row_q.size() > WN) void'(row_q.pop_front());
    m_cnt++;
    if (m_cnt == m_need) begin
      for (int k = 0; k < WN; k++) e[k*SW +: SW] = row_q[k];
      exp_q.push_back(e);
      m_cnt  = 0;
      m_need = 9;
    end
  endtask

  // Every cycle the window is offered it must equal the oldest expected one.
  always @(negedge clk) begin
    if (!rst && win_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL window_unexpected got=%h required=no window", dut_win);
      end else begin
        if (dut_win !== exp_q[0]) begin
          n_miss++;
          $display("FAIL window_content got=%h required=%h", dut_win, exp_q[0]);
        end
        if (win_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called and returning at posedge+1.
  task automatic send(input logic signed [SW-1:0] v, input logic first);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_sample = v;
    in_first  = first;
    in_valid  = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) model_accept(v, first);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    if (!acc) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout got=in_ready low for %0d cycles required=accept", n);
    end
  endtask

  task automatic consume_pulse();
    win_ready = 1'b1;
    @(posedge clk);
    #1;
    win_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0 || win_valid !== 1'b0 || dut_win !== '0) begin
      n_miss++;
      $display("FAIL reset_state got=rdy%b vld%b win=%h required=rdy0 vld0 win=0", in_ready, win_valid, dut_win);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL ready_after_reset got=%b required=1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      send(SW'(i), i == 1);
      if (i == 15) begin
        @(negedge clk);
        n_vec++;
        if (win_valid !== 1'b0) begin
          n_miss++;
          $display("FAIL fill_early_valid got=%b required=0", win_valid);
        end
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    n_vec++;
    if (win_valid !== 1'b1 || w[0] !== 10'sd1 || w[15] !== 10'sd16 || in_ready !== 1'b0) begin
      n_miss++;
      $display("FAIL fill_window got=vld%b w0=%0d w15=%0d rdy%b required=vld1 w0=1 w15=16 rdy0",
               win_valid, w[0], w[15], in_ready);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (win_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_miss++;
      $display("FAIL hold_kept got=vld%b rdy%b required=vld1 rdy0", win_valid, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_step();
    consume_pulse();
    @(negedge clk);
    n_vec++;
    if (win_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL step_entry got=vld%b rdy%b required=vld0 rdy1", win_valid, in_ready);
    end
    @(posedge clk);
    #1;
    for (int i = 17; i <= 24; i++) send(SW'(i), 1'b0);
    @(negedge clk);
    n_vec++;
    if (win_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL step_early_valid got=%b required=0", win_valid);
    end
    @(posedge clk);
    #1;
    send(10'sd25, 1'b0);
    @(negedge clk);
    n_vec++;
    if (win_valid !== 1'b1 || w[0] !== 10'sd10 || w[15] !== 10'sd25) begin
      n_miss++;
      $display("FAIL step_window got=vld%b w0=%0d w15=%0d required=vld1 w0=10 w15=25", win_valid, w[0], w[15]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_extremes();
    consume_pulse();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) send(-10'sd512, i == 0);
      else send(10'sd511, 1'b0);
    end
    @(negedge clk);
    n_vec++;
    if (w[0] !== 10'b10_0000_0000 || w[1] !== 10'b01_1111_1111 || w[15] !== 10'sd511) begin
      n_miss++;
      $display("FAIL extremes got=w0=%b w1=%b w15=%b required=1000000000 0111111111 0111111111", w[0], w[1], w[15]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_restart();
    consume_pulse();
    for (int i = 0; i < 5; i++) send(SW'(200 + i), 1'b0);
    send(10'sd100, 1'b1);
    for (int i = 101; i <= 114; i++) send(SW'(i), 1'b0);
    @(negedge clk);
    n_vec++;
    if (win_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL restart_early_valid got=%b required=0", win_valid);
    end
    @(posedge clk);
    #1;
    send(10'sd115, 1'b0);
    @(negedge clk);
    n_vec++;
    if (win_valid !== 1'b1 || w[0] !== 10'sd100 || w[15] !== 10'sd115) begin
      n_miss++;
      $display("FAIL restart_window got=vld%b w0=%0d w15=%0d required=vld1 w0=100 w15=115", win_valid, w[0], w[15]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_hold();
    rst = 1'b1;
    model_clear();
    #1;
    n_vec++;
    if (win_valid !== 1'b0 || in_ready !== 1'b0 || dut_win !== '0) begin
      n_miss++;
      $display("FAIL reset_in_hold got=vld%b rdy%b win=%h required=vld0 rdy0 win=0", win_valid, in_ready, dut_win);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) send(SW'(300 + i), 1'b0);
    @(negedge clk);
    n_vec++;
    if (win_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL refill_early_valid got=%b required=0", win_valid);
    end
    @(posedge clk);
    #1;
    send(10'sd316, 1'b0);
    @(negedge clk);
    n_vec++;
    if (win_valid !== 1'b1 || w[0] !== 10'sd301 || w[15] !== 10'sd316) begin
      n_miss++;
      $display("FAIL refill_window got=vld%b w0=%0d w15=%0d required=vld1 w0=301 w15=316", win_valid, w[0], w[15]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic                 acc;
    logic signed [SW-1:0] v;
    logic                 f;
    win_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      v = SW'($urandom_range(0, 1023));
      f = ($urandom_range(0, 31) == 0);
      in_sample = v;
      in_first  = f;
      in_valid  = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      if (acc) model_accept(v, f);
      #1;
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL random_drain got=%0d windows pending required=0", exp_q.size());
    end
    win_ready = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fill();
    test_step();
    test_extremes();
    test_restart();
    test_reset_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
